// File: rtl/edge_threshold_if.sv
// rtl/edge_threshold_if.sv - memory bus and start/finish handshake of the edge threshold stage
interface edge_threshold_if;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en;
  logic        we;
  logic        start;
  logic [7:0]  threshold;
  logic        finish;
  logic [16:0] edge_count;

  modport master (
    output addr, dataW, en, we, finish, edge_count,
    input  dataR, start, threshold
  );

  modport slave (
    input  addr, dataW, en, we, finish, edge_count,
    output dataR, start, threshold
  );
endinterface

// File: rtl/edge_threshold.sv
// rtl/edge_threshold.sv - in-place binarization of the edge image against a latched threshold
module edge_threshold #(
  parameter int BASE   = 25344,
  parameter int NWORDS = 25344
) (
  input logic              clk,
  input logic              reset,
  edge_threshold_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [15:0] BASE_A = 16'(BASE);
  localparam logic [15:0] LAST   = 16'(NWORDS - 1);

  state_t      state, state_nx;
  logic [15:0] ptr, ptr_nx;
  logic [16:0] cnt, cnt_nx;
  logic [7:0]  thr_q, thr_nx;
  logic [31:0] bin_word;
  logic [2:0]  ones;

  // Per-byte unsigned compare of the word returned by the previous READ.
  always_comb begin
    bin_word = '0;
    ones     = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dataR[8*i +: 8] >= thr_q) begin
        bin_word[8*i +: 8] = 8'hFF;
        ones               = ones + 3'd1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    cnt_nx     = cnt;
    thr_nx     = thr_q;
    bus.en     = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.dataW  = '0;
    bus.finish = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          thr_nx   = bus.threshold;
          ptr_nx   = '0;
          cnt_nx   = '0;
          state_nx = READ;
        end
      end
      READ: begin
        bus.en   = 1'b1;
        bus.addr = BASE_A + ptr;
        state_nx = WRITE;
      end
      WRITE: begin
        bus.en    = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = BASE_A + ptr;
        bus.dataW = bin_word;
        cnt_nx    = cnt + {14'd0, ones};
        if (ptr == LAST) begin
          state_nx = DONE;
        end else begin
          ptr_nx   = ptr + 16'd1;
          state_nx = READ;
        end
      end
      DONE: begin
        bus.finish = 1'b1;
        if (!bus.start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset kills the bus immediately so an in-flight write never lands.
    if (reset) begin
      bus.en     = 1'b0;
      bus.we     = 1'b0;
      bus.addr   = '0;
      bus.dataW  = '0;
      bus.finish = 1'b0;
    end
  end

  assign bus.edge_count = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      thr_q <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      thr_q <= thr_nx;
    end
  end
endmodule

// File: doc/edge_threshold.md
Name: edge_threshold

Overview:
- Post-processing stage downstream of the Sobel edge-detection accelerator.
- After the accelerator finishes, this block walks the edge-image region of the shared data memory and binarizes every pixel in place against a programmable threshold: pixel >= threshold becomes 0xFF, otherwise 0x00.
- While doing so it counts the pixels that became 0xFF.
- It uses the same single-port word memory interface and start/finish handshake as the accelerator.

Parameters:
- BASE, 25344, word address of the first word of the edge image (352x288 pixels, 4 pixels/word).
- NWORDS, 25344, number of 32-bit words to process; must be >= 1 and BASE+NWORDS-1 <= 65535.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- addr, output, 16, word address to memory.
- dataR, input, 32, read data; valid the cycle after a read request.
- dataW, output, 32, write data.
- en, output, 1, memory request.
- we, output, 1, 1 = write, 0 = read; only meaningful when en=1.
- start, input, 1, begin processing; level signal.
- threshold, input, 8, binarization threshold; sampled in the cycle start is accepted.
- finish, output, 1, high while the result is complete.
- edge_count, output, 17, number of pixels written as 0xFF in the last run; max 101376.

Behaviour:
- Memory model: synchronous read.
  - addr/en=1/we=0 in cycle N gives dataR valid in cycle N+1.
  - Write occurs at the clock edge ending a cycle with en=1/we=1.
  - One access per cycle.
- Pixel packing:
  - dataR[7:0] is the lowest-addressed pixel, dataR[31:24] the highest.
  - The binarized word keeps the same byte positions.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - en=0, we=0, addr=0, dataW=0, finish=0.
  - If start=1: latch threshold into thr_q, ptr<=0, cnt<=0, go to READ.
  - edge_count holds its previous value until start is accepted, then clears to 0.
- READ:
  - en=1, we=0, addr=BASE+ptr, dataW=0, finish=0.
  - Next state is WRITE.
- WRITE:
  - en=1, we=1, addr=BASE+ptr.
  - dataW[8i+7:8i] = (dataR[8i+7:8i] >= thr_q) ? 0xFF : 0x00 for i=0..3. The comparison is unsigned.
  - cnt <= cnt + (number of 0xFF bytes, 0..4).
  - If ptr==NWORDS-1, go to DONE. Otherwise ptr<=ptr+1 and go to READ.
- DONE:
  - finish=1, en=0, we=0, addr=0, dataW=0.
  - edge_count=cnt, stable.
  - Remain while start=1; go to IDLE when start=0.
  - finish drops in the cycle after start falls.
- Throughput: exactly 2 cycles per word.
  - First READ is the cycle after start is sampled.
  - finish rises 2*NWORDS+1 cycles after the cycle start was sampled high in IDLE.
- edge_count is driven from cnt at all times. It is valid only when finish=1 and retains its value in IDLE until the next accepted start.
- Boundaries:
  - threshold=0: every pixel becomes 0xFF, cnt=4*NWORDS.
  - threshold=0xFF: only pixels equal to 0xFF survive.
  - cnt never wraps: 17 bits covers 4*25344.
  - ptr never exceeds NWORDS-1; no access outside [BASE, BASE+NWORDS-1].
  - Each address is read exactly once and written exactly once, in ascending order.
- threshold changes after start is accepted have no effect on the current run.
- start deasserted mid-run: the run continues to completion, then DONE is left immediately on the next cycle (finish pulses 1 cycle).
- reset, at any time including mid-run:
  - Next state IDLE; ptr, cnt, thr_q cleared; edge_count=0.
  - All outputs 0 in the following cycle.
  - An interrupted write is not completed; no further memory access occurs.

Test Plan:
- NWORDS=4, BASE=100, mem[100..103]={0x00FF7F80, 0x01020304, 0xFFFFFFFF, 0x80808080}, threshold=0x80 -> mem={0x00FF0000... per byte: 0x00FF00FF, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFF}, edge_count=10, finish high 9 cycles after start sampled.
- Same memory, threshold=0x00 -> all four words 0xFFFFFFFF, edge_count=16; threshold=0xFF -> {0x00FF0000, 0, 0xFFFFFFFF, 0}, edge_count=5.
- Bus check with default parameters over the full image: addresses strictly alternate read/write BASE+k, k=0..25343, never below 25344 or above 50687; total 50688 accesses; finish after 50689 cycles.
- Change threshold and hold start high through DONE -> result uses the latched threshold; block stays in DONE with finish=1 until start falls, then returns to IDLE within 1 cycle and a new start restarts with edge_count cleared.
- Assert reset during the WRITE of word 2 (NWORDS=4) -> next cycle en=0, we=0, finish=0, edge_count=0; words 2..3 unchanged in memory; a subsequent start processes all 4 words correctly.
- start low for the whole run after acceptance -> finish high for exactly 1 cycle, edge_count stays valid in IDLE afterwards.
